// File: rtl/cpu_defs.sv
// Shared core constants and inter-stage bundle layouts.
// ID unpacks the IF bundle and packs the branch bundle with the same types.
package cpu_defs;

  localparam logic [31:0] RESET_PC = 32'h1c000000;

  localparam int FS_TO_DS_BUS_W = 65;
  localparam int BR_BUS_W       = 33;

  typedef struct packed {
    logic        adef;
    logic [31:0] pc;
    logic [31:0] inst;
  } fs_to_ds_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

endpackage

// File: rtl/if_inst_buf.sv
// Holds the fetched word while ID stalls, since SRAM read data
// is only guaranteed for the cycle right after the fetch.
module if_inst_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] rdata,
  output logic [31:0] inst
);

  logic        buf_valid;
  logic [31:0] buf_data;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      buf_valid <= 1'b0;
    end else if (capture && !buf_valid) begin
      buf_valid <= 1'b1;
      buf_data  <= rdata;
    end
  end

  assign inst = buf_valid ? buf_data : rdata;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: pre-IF next-PC select, IF register and
// instruction SRAM drive, handing {adef, pc, inst} to ID.
module if_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_to_ds_pc,
  output logic [31:0] fs_to_ds_inst,
  output logic        fs_to_ds_adef
);

  br_bus_t     br;
  fs_to_ds_t   fs_to_ds;

  logic        to_fs_valid;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        fs_adef;
  logic [31:0] buf_inst;

  assign br = '{taken: br_taken, target: br_target};

  assign to_fs_valid = ~reset;
  assign seq_pc      = fs_pc + 32'd4;
  assign nextpc      = br.taken ? br.target : seq_pc;

  assign fs_ready_go = 1'b1;
  assign fs_allowin  = ~fs_valid | (fs_ready_go & ds_allowin);

  assign inst_sram_en    = to_fs_valid & fs_allowin;
  assign inst_sram_we    = 4'h0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC - 32'd4;
    end else if (fs_allowin) begin
      fs_valid <= to_fs_valid;
      if (to_fs_valid) begin
        fs_pc <= nextpc;
      end
    end
  end

  // Freeze the word on the first stall cycle; drop it on fire or redirect.
  if_inst_buf u_inst_buf (
    .clk     (clk),
    .reset   (reset),
    .capture (fs_valid & ~ds_allowin),
    .clear   ((fs_valid & ds_allowin) | br.taken),
    .rdata   (inst_sram_rdata),
    .inst    (buf_inst)
  );

  assign fs_adef = fs_pc[1:0] != 2'b00;

  assign fs_to_ds = '{
    adef: fs_adef,
    pc:   fs_pc,
    inst: fs_adef ? 32'h0 : buf_inst
  };

  assign fs_to_ds_valid = fs_valid & fs_ready_go & ~br.taken & ~reset;
  assign fs_to_ds_pc    = fs_to_ds.pc;
  assign fs_to_ds_inst  = fs_to_ds.inst;
  assign fs_to_ds_adef  = fs_to_ds.adef;

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage with a one-cycle-latency
// SRAM model that returns garbage whenever it is not enabled.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [31:0] fs_to_ds_pc;
  logic [31:0] fs_to_ds_inst;
  logic        fs_to_ds_adef;

  int errors = 0;
  int checks = 0;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .ds_allowin      (ds_allowin),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_pc     (fs_to_ds_pc),
    .fs_to_ds_inst   (fs_to_ds_inst),
    .fs_to_ds_adef   (fs_to_ds_adef)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= mem(inst_sram_addr);
    else              inst_sram_rdata <= $urandom;
  end

  typedef struct {
    logic        rst;
    logic        alw;
    logic        br;
    logic [31:0] tgt;
    logic        c_addr;
    logic [31:0] addr;
    logic        en;
    logic        val;
    logic [31:0] pc;
    logic        adef;
  } vec_t;

  vec_t v[30];

  function automatic vec_t mk(
    input logic rst, input logic alw, input logic br,
    input logic [31:0] tgt, input logic c_addr,
    input logic [31:0] addr, input logic en, input logic val,
    input logic [31:0] pc, input logic adef);
    vec_t r;
    r.rst = rst; r.alw = alw; r.br = br; r.tgt = tgt;
    r.c_addr = c_addr; r.addr = addr; r.en = en; r.val = val;
    r.pc = pc; r.adef = adef;
    return r;
  endfunction

  task automatic chk(input string name, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp);
    end
  endtask

  task automatic check_outputs(input int row, input vec_t e);
    chk("sram_en", row, 32'(inst_sram_en), 32'(e.en));
    chk("sram_we", row, 32'(inst_sram_we), 32'h0);
    chk("sram_wdata", row, inst_sram_wdata, 32'h0);
    if (e.c_addr) chk("sram_addr", row, inst_sram_addr, e.addr);
    chk("valid", row, 32'(fs_to_ds_valid), 32'(e.val));
    if (e.val) begin
      chk("pc", row, fs_to_ds_pc, e.pc);
      chk("adef", row, 32'(fs_to_ds_adef), 32'(e.adef));
      chk("inst", row, fs_to_ds_inst, e.adef ? 32'h0 : mem(e.pc));
    end
  endtask

  localparam logic [31:0] B = 32'h1c000000;

  initial begin
    reset      = 1'b1;
    ds_allowin = 1'b1;
    br_taken   = 1'b0;
    br_target  = 32'h0;

    // reset held, then free run
    v[0]  = mk(1, 1, 0, 0, 1, B,          0, 0, 0, 0);
    v[1]  = mk(1, 1, 0, 0, 1, B,          0, 0, 0, 0);
    v[2]  = mk(1, 1, 0, 0, 1, B,          0, 0, 0, 0);
    v[3]  = mk(0, 1, 0, 0, 1, B,          1, 0, 0, 0);
    v[4]  = mk(0, 1, 0, 0, 1, B + 4,      1, 1, B, 0);
    v[5]  = mk(0, 1, 0, 0, 1, B + 8,      1, 1, B + 4, 0);
    // three-cycle stall on 0x1c000008
    v[6]  = mk(0, 0, 0, 0, 1, B + 12,     0, 1, B + 8, 0);
    v[7]  = mk(0, 0, 0, 0, 1, B + 12,     0, 1, B + 8, 0);
    v[8]  = mk(0, 0, 0, 0, 1, B + 12,     0, 1, B + 8, 0);
    v[9]  = mk(0, 1, 0, 0, 1, B + 12,     1, 1, B + 8, 0);
    v[10] = mk(0, 1, 0, 0, 1, B + 16,     1, 1, B + 12, 0);
    // branch while IF holds 0x1c000010
    v[11] = mk(0, 1, 1, B + 32'h100, 1, B + 32'h100, 1, 0, 0, 0);
    v[12] = mk(0, 1, 0, 0, 1, B + 32'h104, 1, 1, B + 32'h100, 0);
    // stall fills buffer, then branch
    v[13] = mk(0, 0, 0, 0, 1, B + 32'h108, 0, 1, B + 32'h104, 0);
    v[14] = mk(0, 0, 0, 0, 1, B + 32'h108, 0, 1, B + 32'h104, 0);
    v[15] = mk(0, 1, 1, B + 32'h200, 1, B + 32'h200, 1, 0, 0, 0);
    v[16] = mk(0, 1, 0, 0, 1, B + 32'h204, 1, 1, B + 32'h200, 0);
    // misaligned target, then realign
    v[17] = mk(0, 1, 1, B + 32'h102, 1, B + 32'h102, 1, 0, 0, 0);
    v[18] = mk(0, 1, 0, 0, 1, B + 32'h106, 1, 1, B + 32'h102, 1);
    v[19] = mk(0, 1, 1, B + 32'h300, 1, B + 32'h300, 1, 0, 0, 0);
    v[20] = mk(0, 1, 0, 0, 1, B + 32'h304, 1, 1, B + 32'h300, 0);
    // reset during a stall with the buffer full
    v[21] = mk(0, 0, 0, 0, 1, B + 32'h308, 0, 1, B + 32'h300 + 4, 0);
    v[22] = mk(0, 0, 0, 0, 1, B + 32'h308, 0, 1, B + 32'h304, 0);
    v[23] = mk(1, 0, 0, 0, 0, 0,          0, 0, 0, 0);
    v[24] = mk(1, 1, 0, 0, 1, B,          0, 0, 0, 0);
    v[25] = mk(0, 1, 0, 0, 1, B,          1, 0, 0, 0);
    v[26] = mk(0, 1, 0, 0, 1, B + 4,      1, 1, B, 0);
    // sequential PC wraps past the top of memory
    v[27] = mk(0, 1, 1, 32'hfffffffc, 1, 32'hfffffffc, 1, 0, 0, 0);
    v[28] = mk(0, 1, 0, 0, 1, 32'h0,      1, 1, 32'hfffffffc, 0);
    v[29] = mk(0, 1, 0, 0, 1, 32'h4,      1, 1, 32'h0, 0);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      reset      = v[i].rst;
      ds_allowin = v[i].alw;
      br_taken   = v[i].br;
      br_target  = v[i].tgt;
      #1;
      check_outputs(i, v[i]);
    end

    // back-to-back throughput after the wrap
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      reset      = 1'b0;
      ds_allowin = 1'b1;
      br_taken   = 1'b0;
      br_target  = 32'h0;
      #1;
      chk("run_valid", 30 + k, 32'(fs_to_ds_valid), 32'h1);
      chk("run_pc", 30 + k, fs_to_ds_pc, 32'(4 + 4 * k));
      chk("run_inst", 30 + k, fs_to_ds_inst, mem(32'(4 + 4 * k)));
      chk("run_addr", 30 + k, inst_sram_addr, 32'(8 + 4 * k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
